// File: rtl/sign_resolve_seq_if.sv
// Handshake bundle for sign_resolve_seq: digit-code input stream and resolved-sign output.
// The slave modport is the resolver side and the master modport is the producer/consumer side.
interface sign_resolve_seq_if #(
    parameter int CNT_WIDTH = 4
);
    logic                 in_valid;
    logic                 in_first;
    logic                 in_last;
    logic [1:0]           in_sign;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [1:0]           out_sign;
    logic [CNT_WIDTH-1:0] out_digits;
    logic                 out_err;

    modport master (
        output in_valid, in_first, in_last, in_sign, out_ready,
        input  in_ready, out_valid, out_sign, out_digits, out_err
    );

    modport slave (
        input  in_valid, in_first, in_last, in_sign, out_ready,
        output in_ready, out_valid, out_sign, out_digits, out_err
    );
endinterface

// File: rtl/sign_resolve_seq.sv
// Digit-serial sign resolver: the first non-equal comparator code (MSD first) decides the frame sign.
// Optional SIGN_RESOLVE_STATS_EN adds saturating frame and error counters.
module sign_resolve_seq #(
    parameter int NUM_DIGITS = 8,
    parameter int CNT_WIDTH  = $clog2(NUM_DIGITS + 1)
) (
    input  logic clk,
    input  logic reset,
    sign_resolve_seq_if.slave bus
`ifdef SIGN_RESOLVE_STATS_EN
    ,
    output logic [15:0] stat_frames,
    output logic [15:0] stat_errs
`endif
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam logic [1:0] CODE_EQ = 2'b01;
    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(NUM_DIGITS);

    logic [1:0]           state, state_n;
    logic [CNT_WIDTH-1:0] count, count_n;
    logic [1:0]           code, code_n;
    logic                 resolved, resolved_n;
    logic                 len_err, len_err_n;
    logic                 seq_err, seq_err_n;
    logic                 code_err, code_err_n;
    logic                 in_ready_q, in_ready_n;
    logic                 out_valid_q, out_valid_n;
    logic [1:0]           out_sign_q, out_sign_n;
    logic [CNT_WIDTH-1:0] out_digits_q, out_digits_n;
    logic                 out_err_q, out_err_n;

    logic       xfer;
    logic       illegal;
    logic [1:0] code_eff;

    assign xfer     = bus.in_valid & in_ready_q;
    assign illegal  = (bus.in_sign == 2'b11);
    assign code_eff = illegal ? CODE_EQ : bus.in_sign;

    always_comb begin
        state_n      = state;
        count_n      = count;
        code_n       = code;
        resolved_n   = resolved;
        len_err_n    = len_err;
        seq_err_n    = seq_err;
        code_err_n   = code_err;
        in_ready_n   = in_ready_q;
        out_valid_n  = out_valid_q;
        out_sign_n   = out_sign_q;
        out_digits_n = out_digits_q;
        out_err_n    = out_err_q;

        case (state)
            IDLE, SCAN: begin
                if (xfer) begin
                    if (bus.in_first) begin
                        // A first beat mid-scan abandons the partial frame and restarts here.
                        if (state == SCAN) seq_err_n = 1'b1;
                        count_n    = CNT_WIDTH'(1);
                        code_n     = code_eff;
                        resolved_n = (code_eff != CODE_EQ);
                        len_err_n  = 1'b0;
                        code_err_n = illegal;
                        state_n    = SCAN;
                    end else if (state == IDLE) begin
                        seq_err_n = 1'b1;
                    end else begin
                        count_n    = count + CNT_WIDTH'(1);
                        code_err_n = code_err | illegal;
                        if (!resolved && code_eff != CODE_EQ) begin
                            code_n     = code_eff;
                            resolved_n = 1'b1;
                        end
                    end

                    if (state_n == SCAN) begin
                        if (bus.in_last) begin
                            state_n = HOLD;
                        end else if (count_n == MAX_CNT) begin
                            state_n   = HOLD;
                            len_err_n = 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_n    = IDLE;
                    count_n    = '0;
                    resolved_n = 1'b0;
                    len_err_n  = 1'b0;
                    seq_err_n  = 1'b0;
                    code_err_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase

        // Output registers load once on HOLD entry and keep sign/digits afterwards.
        if (state_n == HOLD && state != HOLD) begin
            out_valid_n  = 1'b1;
            in_ready_n   = 1'b0;
            out_sign_n   = resolved_n ? code_n : CODE_EQ;
            out_digits_n = count_n;
            out_err_n    = len_err_n | seq_err_n | code_err_n;
        end else if (state == HOLD && state_n != HOLD) begin
            out_valid_n = 1'b0;
            in_ready_n  = 1'b1;
            out_err_n   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            code         <= CODE_EQ;
            resolved     <= 1'b0;
            len_err      <= 1'b0;
            seq_err      <= 1'b0;
            code_err     <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_sign_q   <= CODE_EQ;
            out_digits_q <= '0;
            out_err_q    <= 1'b0;
        end else begin
            state        <= state_n;
            count        <= count_n;
            code         <= code_n;
            resolved     <= resolved_n;
            len_err      <= len_err_n;
            seq_err      <= seq_err_n;
            code_err     <= code_err_n;
            in_ready_q   <= in_ready_n;
            out_valid_q  <= out_valid_n;
            out_sign_q   <= out_sign_n;
            out_digits_q <= out_digits_n;
            out_err_q    <= out_err_n;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_sign   = out_sign_q;
    assign bus.out_digits = out_digits_q;
    assign bus.out_err    = out_err_q;

`ifdef SIGN_RESOLVE_STATS_EN
    logic handshake;
    assign handshake = out_valid_q & bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_frames <= '0;
            stat_errs   <= '0;
        end else if (handshake) begin
            if (stat_frames != 16'hFFFF) stat_frames <= stat_frames + 16'd1;
            if (out_err_q && stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_sign_resolve_seq.sv
// Directed testbench for sign_resolve_seq; observed outputs are packed as
// {out_valid, in_ready, out_sign, out_digits, out_err} and compared to hand-computed vectors.
module tb_sign_resolve_seq;
    logic clk;
    logic reset;
    int   num_vectors;
    int   num_miscompares;

    sign_resolve_seq_if #(.CNT_WIDTH(4)) bus ();

`ifdef SIGN_RESOLVE_STATS_EN
    logic [15:0] stat_frames;
    logic [15:0] stat_errs;
`endif

    sign_resolve_seq #(.NUM_DIGITS(8), .CNT_WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef SIGN_RESOLVE_STATS_EN
        ,
        .stat_frames (stat_frames),
        .stat_errs   (stat_errs)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [8:0] obs;
    assign obs = {bus.out_valid, bus.in_ready, bus.out_sign, bus.out_digits, bus.out_err};

    task automatic beat(input logic f, input logic l, input logic [1:0] s);
        bus.in_valid = 1'b1;
        bus.in_first = f;
        bus.in_last  = l;
        bus.in_sign  = s;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        num_vectors++;
        if (obs !== 9'b0_1_01_0000_0) begin
            num_miscompares++;
            $display("[TB] FAIL reset_async: got %b expected %b", obs, 9'b0_1_01_0000_0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        num_vectors++;
        if (obs !== 9'b0_1_01_0000_0) begin
            num_miscompares++;
            $display("[TB] FAIL reset_release: got %b expected %b", obs, 9'b0_1_01_0000_0);
        end
    endtask

    task automatic test_basic();
        logic [1:0] codes [4];
        codes = '{2'b01, 2'b01, 2'b10, 2'b00};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            beat(i == 0, 1'b0, codes[i]);
            num_vectors++;
            if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
                num_miscompares++;
                $display("[TB] FAIL basic_scan%0d: got %b expected 01", i, {bus.out_valid, bus.in_ready});
            end
        end
        beat(1'b0, 1'b1, codes[3]);
        num_vectors++;
        if (obs !== 9'b1_0_10_0100_0) begin
            num_miscompares++;
            $display("[TB] FAIL basic_hold: got %b expected %b", obs, 9'b1_0_10_0100_0);
        end
        idle_cycle();
        num_vectors++;
        if (obs !== 9'b0_1_10_0100_0) begin
            num_miscompares++;
            $display("[TB] FAIL basic_release: got %b expected %b", obs, 9'b0_1_10_0100_0);
        end
    endtask

    task automatic test_single();
        beat(1'b1, 1'b1, 2'b00);
        num_vectors++;
        if (obs !== 9'b1_0_00_0001_0) begin
            num_miscompares++;
            $display("[TB] FAIL single_hold: got %b expected %b", obs, 9'b1_0_00_0001_0);
        end
        idle_cycle();
        num_vectors++;
        if (obs !== 9'b0_1_00_0001_0) begin
            num_miscompares++;
            $display("[TB] FAIL single_release: got %b expected %b", obs, 9'b0_1_00_0001_0);
        end
    endtask

    task automatic test_all_equal();
        for (int i = 0; i < 8; i++) beat(i == 0, i == 7, 2'b01);
        num_vectors++;
        if (obs !== 9'b1_0_01_1000_0) begin
            num_miscompares++;
            $display("[TB] FAIL equal8_last: got %b expected %b", obs, 9'b1_0_01_1000_0);
        end
        idle_cycle();
        for (int i = 0; i < 8; i++) begin
            beat(i == 0, 1'b0, 2'b01);
            if (i == 6) begin
                num_vectors++;
                if (bus.out_valid !== 1'b0) begin
                    num_miscompares++;
                    $display("[TB] FAIL equal8_early: got out_valid=%b expected 0", bus.out_valid);
                end
            end
        end
        num_vectors++;
        if (obs !== 9'b1_0_01_1000_1) begin
            num_miscompares++;
            $display("[TB] FAIL equal8_forced: got %b expected %b", obs, 9'b1_0_01_1000_1);
        end
        idle_cycle();
        num_vectors++;
        if (obs !== 9'b0_1_01_1000_0) begin
            num_miscompares++;
            $display("[TB] FAIL equal8_release: got %b expected %b", obs, 9'b0_1_01_1000_0);
        end
    endtask

    task automatic test_hold_stall();
        bus.out_ready = 1'b0;
        beat(1'b1, 1'b0, 2'b00);
        beat(1'b0, 1'b1, 2'b10);
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.in_first = 1'b1;
            bus.in_last  = 1'b1;
            bus.in_sign  = 2'b10;
            num_vectors++;
            if (obs !== 9'b1_0_00_0010_0) begin
                num_miscompares++;
                $display("[TB] FAIL stall%0d: got %b expected %b", k, obs, 9'b1_0_00_0010_0);
            end
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        idle_cycle();
        num_vectors++;
        if (obs !== 9'b0_1_00_0010_0) begin
            num_miscompares++;
            $display("[TB] FAIL stall_release: got %b expected %b", obs, 9'b0_1_00_0010_0);
        end
        idle_cycle();
        num_vectors++;
        if (obs !== 9'b0_1_00_0010_0) begin
            num_miscompares++;
            $display("[TB] FAIL stall_no_phantom: got %b expected %b", obs, 9'b0_1_00_0010_0);
        end
    endtask

    task automatic test_restart();
        beat(1'b1, 1'b0, 2'b01);
        beat(1'b0, 1'b0, 2'b01);
        beat(1'b1, 1'b0, 2'b00);
        beat(1'b0, 1'b1, 2'b10);
        num_vectors++;
        if (obs !== 9'b1_0_00_0010_1) begin
            num_miscompares++;
            $display("[TB] FAIL restart: got %b expected %b", obs, 9'b1_0_00_0010_1);
        end
        idle_cycle();
    endtask

    task automatic test_illegal();
        beat(1'b1, 1'b0, 2'b11);
        beat(1'b0, 1'b0, 2'b01);
        beat(1'b0, 1'b1, 2'b10);
        num_vectors++;
        if (obs !== 9'b1_0_10_0011_1) begin
            num_miscompares++;
            $display("[TB] FAIL illegal_first: got %b expected %b", obs, 9'b1_0_10_0011_1);
        end
        idle_cycle();
        beat(1'b1, 1'b1, 2'b11);
        num_vectors++;
        if (obs !== 9'b1_0_01_0001_1) begin
            num_miscompares++;
            $display("[TB] FAIL illegal_only: got %b expected %b", obs, 9'b1_0_01_0001_1);
        end
        idle_cycle();
        beat(1'b1, 1'b0, 2'b10);
        beat(1'b0, 1'b1, 2'b11);
        num_vectors++;
        if (obs !== 9'b1_0_10_0010_1) begin
            num_miscompares++;
            $display("[TB] FAIL illegal_after_resolve: got %b expected %b", obs, 9'b1_0_10_0010_1);
        end
        idle_cycle();
    endtask

    task automatic test_stray();
        beat(1'b0, 1'b0, 2'b10);
        num_vectors++;
        if (obs !== 9'b0_1_10_0010_0) begin
            num_miscompares++;
            $display("[TB] FAIL stray_dropped: got %b expected %b", obs, 9'b0_1_10_0010_0);
        end
        beat(1'b1, 1'b1, 2'b00);
        num_vectors++;
        if (obs !== 9'b1_0_00_0001_1) begin
            num_miscompares++;
            $display("[TB] FAIL stray_reported: got %b expected %b", obs, 9'b1_0_00_0001_1);
        end
        idle_cycle();
        beat(1'b1, 1'b1, 2'b00);
        num_vectors++;
        if (obs !== 9'b1_0_00_0001_0) begin
            num_miscompares++;
            $display("[TB] FAIL stray_cleared: got %b expected %b", obs, 9'b1_0_00_0001_0);
        end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        beat(1'b1, 1'b1, 2'b10);
        num_vectors++;
        if (obs !== 9'b1_0_10_0001_0) begin
            num_miscompares++;
            $display("[TB] FAIL b2b_first: got %b expected %b", obs, 9'b1_0_10_0001_0);
        end
        beat(1'b1, 1'b1, 2'b00);
        num_vectors++;
        if (obs !== 9'b0_1_10_0001_0) begin
            num_miscompares++;
            $display("[TB] FAIL b2b_not_taken_in_hold: got %b expected %b", obs, 9'b0_1_10_0001_0);
        end
        @(posedge clk);
        #1;
        num_vectors++;
        if (obs !== 9'b1_0_00_0001_0) begin
            num_miscompares++;
            $display("[TB] FAIL b2b_second: got %b expected %b", obs, 9'b1_0_00_0001_0);
        end
        idle_cycle();
    endtask

    task automatic test_async_reset();
        beat(1'b1, 1'b0, 2'b10);
        beat(1'b0, 1'b0, 2'b01);
        #2;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        num_vectors++;
        if (obs !== 9'b0_1_01_0000_0) begin
            num_miscompares++;
            $display("[TB] FAIL midscan_reset: got %b expected %b", obs, 9'b0_1_01_0000_0);
        end
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        beat(1'b1, 1'b0, 2'b10);
        beat(1'b0, 1'b0, 2'b00);
        beat(1'b0, 1'b1, 2'b01);
        num_vectors++;
        if (obs !== 9'b1_0_10_0011_0) begin
            num_miscompares++;
            $display("[TB] FAIL post_reset_frame: got %b expected %b", obs, 9'b1_0_10_0011_0);
        end
        idle_cycle();
    endtask

    initial begin
        num_vectors     = 0;
        num_miscompares = 0;
        bus.in_valid    = 1'b0;
        bus.in_first    = 1'b0;
        bus.in_last     = 1'b0;
        bus.in_sign     = 2'b01;
        bus.out_ready   = 1'b1;
        test_reset();
        test_basic();
        test_single();
        test_all_equal();
        test_hold_stall();
        test_restart();
        test_illegal();
        test_stray();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
        $finish;
    end
endmodule
